gate_sequencer: RTL and testbench

Programmable scheduler for a bank of `N_CH` gate/delay pulse channels. On an external start trigger it walks a small step table. Each step loads one channel's delay and width, then fires that channel's one-cycle trigger, and the step's gap sets the spacing to the next step. The block sits between the host register interface and the gate/delay generator instances, which it configures and sequences.

---
 rtl/gate_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_gate_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sequencer.sv
// gate_sequencer: step-table scheduler that loads delay/width into a bank of
// gate/delay pulse channels and fires their triggers on an external start.
module gate_sequencer #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [15:0]              i_repeat,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [1:0]               i_wr_sel,
  input  logic [31:0]              i_wr_data,
  input  logic [N_CH-1:0]          i_ch_busy,
  output logic [N_CH-1:0]          o_ch_trig,
  output logic [32*N_CH-1:0]       o_ch_delay,
  output logic [32*N_CH-1:0]       o_ch_width,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_miss,
  output logic                     o_stall
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   step_q, step_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]     pass_q, pass_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            sync3_q, sync3_d;
  logic            start_evt_q, start_evt_d;
  logic            stall_q, stall_d;
  logic            done_q, done_d;
  logic            miss_q, miss_d;
  logic            busy_q, busy_d;
  logic [N_CH-1:0] trig_q, trig_d;

  logic [31:0] ch_delay_q [N_CH];
  logic [31:0] ch_delay_d [N_CH];
  logic [31:0] ch_width_q [N_CH];
  logic [31:0] ch_width_d [N_CH];

  logic [31:0] tbl_delay_q [DEPTH];
  logic [31:0] tbl_delay_d [DEPTH];
  logic [31:0] tbl_width_q [DEPTH];
  logic [31:0] tbl_width_d [DEPTH];
  logic [1:0]  tbl_ch_q    [DEPTH];
  logic [1:0]  tbl_ch_d    [DEPTH];
  logic        tbl_last_q  [DEPTH];
  logic        tbl_last_d  [DEPTH];
  logic [15:0] tbl_gap_q   [DEPTH];
  logic [15:0] tbl_gap_d   [DEPTH];

  logic [1:0]      cur_ch;
  logic [31:0]     cur_delay;
  logic [31:0]     cur_width;
  logic [15:0]     cur_gap;
  logic            cur_last;
  logic [15:0]     gap_load;
  logic [15:0]     repeat_load;
  logic            pass_end;
  logic [N_CH-1:0] ch_sel;
  logic            ch_valid;
  logic            busy_hit;
  logic            wr_ok;
  logic            unused_ctrl_bits;

  assign unused_ctrl_bits = ^{i_wr_data[15:9], i_wr_data[7:2]};

  // Decode of the step currently addressed by step_q.
  always_comb begin
    cur_ch      = tbl_ch_q[step_q];
    cur_delay   = tbl_delay_q[step_q];
    cur_width   = tbl_width_q[step_q];
    cur_gap     = tbl_gap_q[step_q];
    cur_last    = tbl_last_q[step_q];
    gap_load    = (cur_gap == 16'd0) ? 16'd0 : cur_gap - 16'd1;
    repeat_load = (i_repeat == 16'd0) ? 16'd1 : i_repeat;
    pass_end    = cur_last || (step_q == AW'(DEPTH - 1));
    ch_sel      = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_sel[c] = (cur_ch == 2'(c));
    end
    // An index beyond the channel bank selects nothing: no stall, no trigger.
    ch_valid = |ch_sel;
    busy_hit = |(ch_sel & i_ch_busy);
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    step_d      = step_q;
    gap_cnt_d   = gap_cnt_q;
    pass_d      = pass_q;
    stall_d     = stall_q;
    trig_d      = '0;
    done_d      = 1'b0;
    miss_d      = 1'b0;
    ch_delay_d  = ch_delay_q;
    ch_width_d  = ch_width_q;
    tbl_delay_d = tbl_delay_q;
    tbl_width_d = tbl_width_q;
    tbl_ch_d    = tbl_ch_q;
    tbl_last_d  = tbl_last_q;
    tbl_gap_d   = tbl_gap_q;

    sync1_d     = i_start;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    start_evt_d = sync2_q & ~sync3_q;

    if (start_evt_q && (state_q != S_IDLE)) begin
      miss_d = 1'b1;
    end

    wr_ok = i_wr_en && (state_q == S_IDLE) && !busy_q;
    if (wr_ok) begin
      case (i_wr_sel)
        2'd0: tbl_delay_d[i_wr_addr] = i_wr_data;
        2'd1: tbl_width_d[i_wr_addr] = i_wr_data;
        2'd2: begin
          tbl_ch_d[i_wr_addr]   = i_wr_data[1:0];
          tbl_last_d[i_wr_addr] = i_wr_data[8];
          tbl_gap_d[i_wr_addr]  = i_wr_data[31:16];
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_evt_q && !i_abort) begin
          pass_d  = repeat_load;
          step_d  = '0;
          stall_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (busy_hit) begin
          stall_d = 1'b1;
        end else begin
          for (int c = 0; c < N_CH; c++) begin
            if (ch_sel[c]) begin
              ch_delay_d[c] = cur_delay;
              ch_width_d[c] = cur_width;
            end
          end
          trig_d    = ch_valid ? ch_sel : '0;
          gap_cnt_d = gap_load;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q != 16'd0) begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end else if (pass_end) begin
          if (pass_q > 16'd1) begin
            pass_d  = pass_q - 16'd1;
            step_d  = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          step_d  = step_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = !i_abort;
      end
      default: state_d = S_IDLE;
    endcase

    // Busy stays up through the cycle that carries the done pulse.
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      gap_cnt_q   <= '0;
      pass_q      <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      start_evt_q <= 1'b0;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_q      <= '0;
      ch_delay_q  <= '{default: '0};
      ch_width_q  <= '{default: '0};
      // NOTE: the step table is a small register file and is cleared on reset, so a run started before any write sees defined steps.
      tbl_delay_q <= '{default: '0};
      tbl_width_q <= '{default: '0};
      tbl_ch_q    <= '{default: '0};
      tbl_last_q  <= '{default: '0};
      tbl_gap_q   <= '{default: '0};
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      step_q      <= step_d;
      gap_cnt_q   <= gap_cnt_d;
      pass_q      <= pass_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      start_evt_q <= start_evt_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
      busy_q      <= busy_d;
      trig_q      <= trig_d;
      ch_delay_q  <= ch_delay_d;
      ch_width_q  <= ch_width_d;
      tbl_delay_q <= tbl_delay_d;
      tbl_width_q <= tbl_width_d;
      tbl_ch_q    <= tbl_ch_d;
      tbl_last_q  <= tbl_last_d;
      tbl_gap_q   <= tbl_gap_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_pack
    assign o_ch_delay[32*c +: 32] = ch_delay_q[c];
    assign o_ch_width[32*c +: 32] = ch_width_q[c];
  end

  assign o_ch_trig = trig_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_miss    = miss_q;
  assign o_stall   = stall_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: directed and randomized runs compared against an
// event-timeline model computed from the step table.
module tb_gate_sequencer;

  localparam int N_CH  = 3;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort_in;
  logic [15:0]         rep_cnt;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [1:0]          wr_sel;
  logic [31:0]         wr_data;
  logic [N_CH-1:0]     ch_busy;
  logic [N_CH-1:0]     ch_trig;
  logic [32*N_CH-1:0]  ch_delay;
  logic [32*N_CH-1:0]  ch_width;
  logic                busy;
  logic                done;
  logic                miss;
  logic                stall;

  gate_sequencer #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort_in),
    .i_repeat   (rep_cnt),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_sel   (wr_sel),
    .i_wr_data  (wr_data),
    .i_ch_busy  (ch_busy),
    .o_ch_trig  (ch_trig),
    .o_ch_delay (ch_delay),
    .o_ch_width (ch_width),
    .o_busy     (busy),
    .o_done     (done),
    .o_miss     (miss),
    .o_stall    (stall)
  );

  always #5 clk = ~clk;

  // Edge counter: during the cycle before edge E it holds E-1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Busy window: channel busy_ch is seen high at edges [busy_from, busy_from+busy_len).
  int busy_from = 0;
  int busy_len  = 0;
  int busy_ch   = 0;
  assign ch_busy = ((cyc + 1 >= busy_from) && (cyc + 1 < busy_from + busy_len)) ?
                   N_CH'(1 << busy_ch) : '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference table and channel-register image.
  int          m_ch   [DEPTH];
  int          m_gap  [DEPTH];
  bit          m_last [DEPTH];
  logic [31:0] m_dly  [DEPTH];
  logic [31:0] m_wid  [DEPTH];
  logic [31:0] m_cd   [N_CH];
  logic [31:0] m_cw   [N_CH];
  bit          m_stall;

  typedef struct {
    int          edge_n;
    int          ch;
    logic [31:0] dly;
    logic [31:0] wid;
  } trig_t;

  trig_t obs_q[$];
  trig_t exp_q[$];
  int    obs_done[$];
  int    obs_miss[$];
  int    rise_n;
  int    rise_e;
  int    fall_e;
  bit    mon_en = 1'b0;
  logic  busy_prev;
  trig_t mon_r;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_trig[c] === 1'b1) begin
          mon_r.edge_n = cyc;
          mon_r.ch     = c;
          mon_r.dly    = ch_delay[32*c +: 32];
          mon_r.wid    = ch_width[32*c +: 32];
          obs_q.push_back(mon_r);
        end
      end
      if (done === 1'b1) obs_done.push_back(cyc);
      if (miss === 1'b1) obs_miss.push_back(cyc);
      if (busy === 1'b1 && busy_prev !== 1'b1) begin
        rise_n++;
        rise_e = cyc;
      end
      if (busy !== 1'b1 && busy_prev === 1'b1) fall_e = cyc;
      busy_prev = busy;
    end
  end

  task automatic tbl_write(input int addr, input int sel, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_sel  = 2'(sel);
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    case (sel)
      0: m_dly[addr] = data;
      1: m_wid[addr] = data;
      2: begin
        m_ch[addr]   = int'(data[1:0]);
        m_last[addr] = data[8];
        m_gap[addr]  = int'(data[31:16]);
      end
      default: ;
    endcase
  endtask

  task automatic prog_step(input int s, input int ch, input logic [31:0] dly,
                           input logic [31:0] wid, input int gap, input bit last);
    logic [31:0] ctrl;
    ctrl        = $urandom;
    ctrl[1:0]   = 2'(ch);
    ctrl[8]     = last;
    ctrl[31:16] = 16'(gap);
    tbl_write(s, 0, dly);
    tbl_write(s, 1, wid);
    tbl_write(s, 2, ctrl);
  endtask

  // One run: the start pulse is sampled high at edges e0 and e0+1.
  task automatic run(input int rep, input int bch, input int boff, input int blen,
                     input int abort_off, input int miss_off, input bit mid_wr);
    int    e0, t, passes, done_e, abort_e, first_stall, end_off, gsp;
    bit    run_starts, aborted;
    trig_t r;
    trig_t keep[$];

    rep_cnt   = 16'(rep);
    e0        = cyc + 1;
    busy_ch   = bch;
    busy_from = e0 + boff;
    busy_len  = blen;

    passes      = (rep == 0) ? 1 : rep;
    t           = e0 + 4;
    first_stall = 0;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (m_ch[s] < N_CH) begin
          while (m_ch[s] == bch && t >= busy_from && t < busy_from + blen) begin
            if (first_stall == 0) first_stall = t;
            t++;
          end
          r.edge_n = t;
          r.ch     = m_ch[s];
          r.dly    = m_dly[s];
          r.wid    = m_wid[s];
          exp_q.push_back(r);
        end
        gsp = (m_gap[s] == 0) ? 1 : m_gap[s];
        t   = t + gsp + 1;
        if (m_last[s]) break;
      end
    end
    done_e = t;

    abort_e    = (abort_off > 0) ? e0 + abort_off : 0;
    run_starts = (abort_off != 3);
    aborted    = run_starts && (abort_off >= 4) && (abort_e <= done_e);
    keep.delete();
    if (run_starts) begin
      foreach (exp_q[i]) if (!aborted || exp_q[i].edge_n < abort_e) keep.push_back(exp_q[i]);
      m_stall = (first_stall != 0) && (!aborted || first_stall < abort_e);
    end
    foreach (keep[i]) begin
      m_cd[keep[i].ch] = keep[i].dly;
      m_cw[keep[i].ch] = keep[i].wid;
    end
    end_off = run_starts ? ((aborted ? abort_e : done_e + 1) - e0 + 6) : 12;

    obs_q.delete();
    obs_done.delete();
    obs_miss.delete();
    rise_n    = 0;
    rise_e    = 0;
    fall_e    = 0;
    busy_prev = busy;
    mon_en    = 1'b1;
    for (int k = 0; k <= end_off; k++) begin
      start    = (k < 2) || (miss_off > 0 && k >= miss_off && k < miss_off + 2);
      abort_in = (abort_off > 0) && (k == abort_off);
      if (mid_wr && k == 6) begin
        wr_en = 1'b1; wr_addr = '0; wr_sel = 2'd0; wr_data = 32'd999;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    mon_en   = 1'b0;
    start    = 1'b0;
    abort_in = 1'b0;
    wr_en    = 1'b0;
    busy_len = 0;

    check("n_trig", obs_q.size(), keep.size());
    for (int i = 0; i < keep.size() && i < obs_q.size(); i++) begin
      check("trig_edge", obs_q[i].edge_n - e0, keep[i].edge_n - e0);
      check("trig_ch", obs_q[i].ch, keep[i].ch);
      check("trig_delay", obs_q[i].dly, keep[i].dly);
      check("trig_width", obs_q[i].wid, keep[i].wid);
    end
    check("n_done", obs_done.size(), (run_starts && !aborted) ? 1 : 0);
    if (run_starts && !aborted && obs_done.size() > 0)
      check("done_edge", obs_done[0] - e0, done_e - e0);
    check("n_busy_rise", rise_n, run_starts ? 1 : 0);
    if (run_starts) begin
      check("busy_rise", rise_e - e0, 3);
      check("busy_fall", fall_e - e0, (aborted ? abort_e : done_e + 1) - e0);
    end
    check("n_miss", obs_miss.size(), (miss_off > 0) ? 1 : 0);
    if (miss_off > 0 && obs_miss.size() > 0)
      check("miss_edge", obs_miss[0] - e0, miss_off + 3);
    check("stall", stall, m_stall);
    for (int c = 0; c < N_CH; c++) begin
      check("ch_delay", ch_delay[32*c +: 32], m_cd[c]);
      check("ch_width", ch_width[32*c +: 32], m_cw[c]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort_in = 1'b0;
    rep_cnt  = 16'd1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_sel   = '0;
    wr_data  = '0;
    m_stall  = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      m_ch[s] = 0; m_gap[s] = 0; m_last[s] = 1'b0; m_dly[s] = '0; m_wid[s] = '0;
    end
    for (int c = 0; c < N_CH; c++) begin
      m_cd[c] = '0; m_cw[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_trig", ch_trig, 0);
    check("rst_delay", ch_delay, 0);
    check("rst_width", ch_width, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_miss", miss, 0);
    check("rst_stall", stall, 0);

    // Reset table: eight ch0 steps with zero gap.
    run(1, 0, 0, 0, 0, 0, 1'b0);

    prog_step(0, 1, 32'd10, 32'd5, 4, 1'b0);
    prog_step(1, 2, 32'd3, 32'd2, 0, 1'b1);
    tbl_write(1, 3, 32'hdead_beef);
    run(1, 0, 0, 0, 0, 0, 1'b0);
    run(3, 0, 0, 0, 0, 0, 1'b0);
    run(1, 1, 4, 7, 0, 0, 1'b0);
    run(1, 0, 0, 0, 0, 5, 1'b1);
    run(1, 0, 0, 0, 6, 0, 1'b0);
    run(1, 0, 0, 0, 3, 0, 1'b0);
    run(0, 0, 0, 0, 0, 0, 1'b0);

    // Full depth, no last flags, one out-of-range channel.
    for (int s = 0; s < DEPTH; s++)
      prog_step(s, (s == 5) ? 3 : s % 3, 32'(100 + s), 32'(200 + s), s % 3, 1'b0);
    run(2, 2, 10, 3, 0, 0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      for (int s = 0; s < DEPTH; s++)
        prog_step(s, $urandom_range(3, 0), $urandom, $urandom,
                  $urandom_range(5, 0), ($urandom_range(3, 0) == 0));
      tbl_write($urandom_range(DEPTH - 1, 0), 3, $urandom);
      run($urandom_range(3, 0), $urandom_range(N_CH - 1, 0), $urandom_range(22, 3),
          $urandom_range(4, 0), 0, 0, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
